// File: rtl/data_mem_responder_if.sv
// Request/response bus between a memory client and data_mem_responder.
interface data_mem_responder_if;
  logic [1:0]  mem_op;
  logic [15:0] mem_rw_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_err;
  logic [15:0] err_addr;

  modport master (
    output mem_op, mem_rw_addr, mem_wdata,
    input  mem_ready, mem_rdata, mem_rdata_valid, mem_err, err_addr
  );

  modport slave (
    input  mem_op, mem_rw_addr, mem_wdata,
    output mem_ready, mem_rdata, mem_rdata_valid, mem_err, err_addr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port 16-bit data memory that self-clears after reset, then serves one
// read or write per cycle with a one-cycle read latency and error reporting.
module data_mem_responder #(
  parameter int unsigned DATA_MEM_SIZE = 256
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW = (DATA_MEM_SIZE > 1) ? $clog2(DATA_MEM_SIZE) : 1;
  localparam int unsigned DW = 16;

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  logic [DW-1:0] mem_q [DATA_MEM_SIZE];

  state_e        state_q, state_d;
  logic [AW-1:0] init_ptr_q, init_ptr_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic          err_q, err_d;
  logic [DW-1:0] err_addr_q, err_addr_d;

  logic          in_range_c;
  logic [AW-1:0] idx_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_waddr_c;
  logic [DW-1:0] mem_wdata_c;

  assign in_range_c = 32'(bus.mem_rw_addr) < DATA_MEM_SIZE;
  assign idx_c      = AW'(bus.mem_rw_addr);

  // Next-state, response and array-write decode
  always_comb begin
    state_d       = state_q;
    init_ptr_d    = init_ptr_q;
    ready_d       = ready_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;
    err_addr_d    = err_addr_q;
    mem_we_c      = 1'b0;
    mem_waddr_c   = idx_c;
    mem_wdata_c   = bus.mem_wdata;

    unique case (state_q)
      ST_INIT: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = init_ptr_q;
        mem_wdata_c = '0;
        if (init_ptr_q == AW'(DATA_MEM_SIZE - 1)) begin
          state_d    = ST_IDLE;
          ready_d    = 1'b1;
          init_ptr_d = '0;
        end else begin
          init_ptr_d = init_ptr_q + AW'(1);
        end
        // Requests during clearing are rejected, not queued
        if (bus.mem_op != MEM_NOP) begin
          err_d      = 1'b1;
          err_addr_d = bus.mem_rw_addr;
        end
      end
      ST_IDLE: begin
        case (bus.mem_op)
          MEM_NOP: ;
          MEM_READ: begin
            rdata_valid_d = 1'b1;
            if (in_range_c) begin
              rdata_d = mem_q[idx_c];
            end else begin
              rdata_d    = '0;
              err_d      = 1'b1;
              err_addr_d = bus.mem_rw_addr;
            end
          end
          MEM_WRITE: begin
            if (in_range_c) begin
              mem_we_c = 1'b1;
            end else begin
              err_d      = 1'b1;
              err_addr_d = bus.mem_rw_addr;
            end
          end
          default: begin
            err_d      = 1'b1;
            err_addr_d = bus.mem_rw_addr;
          end
        endcase
      end
      default: ;
    endcase

    // Reset wins over any array update sampled at the same edge
    if (reset) begin
      mem_we_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      init_ptr_q    <= '0;
      ready_q       <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
      err_addr_q    <= err_addr_d;
    end
  end

  // Array storage has no reset; the INIT sweep clears it
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign bus.mem_ready       = ready_q;
  assign bus.mem_rdata       = rdata_q;
  assign bus.mem_rdata_valid = rdata_valid_q;
  assign bus.mem_err         = err_q;
  assign bus.err_addr        = err_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expected pulses,
// a monitor pops them and also tracks the held rdata / err_addr values.
module tb_data_mem_responder;

  localparam int unsigned SIZE = 256;
  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef struct {
    logic        valid;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] eaddr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  data_mem_responder_if bus();

  data_mem_responder #(.DATA_MEM_SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] hold_rdata;
  logic [15:0] hold_eaddr;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd);
    @(negedge clk);
    bus.mem_op      = op;
    bus.mem_rw_addr = addr;
    bus.mem_wdata   = wd;
  endtask

  task automatic push(input logic v, input logic e, input logic [15:0] rd, input logic [15:0] ea);
    exp_t x;
    x.valid = v;
    x.err   = e;
    x.rdata = rd;
    x.eaddr = ea;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(OP_NOP, 16'h0000, 16'h0000);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 16'(bus.mem_ready), 16'h0000);
    chk({tag, "_rdata"}, bus.mem_rdata, 16'h0000);
    chk({tag, "_valid"}, 16'(bus.mem_rdata_valid), 16'h0000);
    chk({tag, "_err"}, 16'(bus.mem_err), 16'h0000);
    chk({tag, "_err_addr"}, bus.err_addr, 16'h0000);
  endtask

  // Called at the negedge where reset is released; ready must rise after exactly SIZE edges
  task automatic wait_ready(input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 1000 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.mem_ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != int'(SIZE)) begin
      errors++;
      $display("FAIL %s: mem_ready rose after %0d cycles (seen=%0d), expected %0d", name, n, seen, SIZE);
    end
  endtask

  // Monitor: pops an expectation on every pulse, checks held outputs every cycle
  initial begin
    exp_t e;
    logic rst_s;
    hold_rdata = '0;
    hold_eaddr = '0;
    @(posedge clk);
    forever begin
      @(posedge clk);
      rst_s = reset;
      #1;
      if (rst_s) begin
        hold_rdata = '0;
        hold_eaddr = '0;
      end
      if (bus.mem_rdata_valid === 1'b1 || bus.mem_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: valid=%b err=%b, expected no pulse at %0t",
                   bus.mem_rdata_valid, bus.mem_err, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rdata_valid", 16'(bus.mem_rdata_valid), 16'(e.valid));
          chk("mem_err", 16'(bus.mem_err), 16'(e.err));
          if (e.valid) hold_rdata = e.rdata;
          if (e.err)   hold_eaddr = e.eaddr;
        end
      end
      chk("mem_rdata", bus.mem_rdata, hold_rdata);
      chk("err_addr", bus.err_addr, hold_eaddr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.mem_op      = OP_NOP;
    bus.mem_rw_addr = 16'h0000;
    bus.mem_wdata   = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;
    wait_ready("init_por");

    drive(OP_RD, 16'h00FF, 16'h0000); push(1'b1, 1'b0, 16'h0000, 16'h0000);

    drive(OP_WR, 16'h0010, 16'hBEEF);
    drive(OP_RD, 16'h0010, 16'h0000); push(1'b1, 1'b0, 16'hBEEF, 16'h0000);
    idle(2);

    // Back-to-back errors, then confirm the aliasing word 0 is untouched
    drive(OP_RD, 16'h0100, 16'h0000); push(1'b1, 1'b1, 16'h0000, 16'h0100);
    drive(OP_WR, 16'h0200, 16'h1234); push(1'b0, 1'b1, 16'h0000, 16'h0200);
    drive(OP_RD, 16'h0000, 16'h0000); push(1'b1, 1'b0, 16'h0000, 16'h0000);
    idle(1);

    drive(OP_RSV, 16'h0005, 16'hFFFF); push(1'b0, 1'b1, 16'h0000, 16'h0005);
    idle(1);

    drive(OP_WR, 16'h0001, 16'h1111);
    idle(1);
    drive(OP_RD, 16'h0001, 16'h0000); push(1'b1, 1'b0, 16'h1111, 16'h0000);
    drive(OP_WR, 16'h0002, 16'hAAAA);
    drive(OP_RD, 16'h0002, 16'h0000); push(1'b1, 1'b0, 16'hAAAA, 16'h0000);
    idle(3);

    // Write coincident with reset must be dropped
    @(negedge clk);
    reset           = 1'b1;
    bus.mem_op      = OP_WR;
    bus.mem_rw_addr = 16'h0020;
    bus.mem_wdata   = 16'h5555;
    @(negedge clk);
    bus.mem_op = OP_NOP;
    @(negedge clk);
    check_reset_state("mid");
    reset = 1'b0;

    idle(9);
    drive(OP_RD, 16'h0042, 16'h0000); push(1'b0, 1'b1, 16'h0000, 16'h0042);
    idle(89);

    // Reset at INIT cycle ~100 with a read presented: no error, clearing restarts
    @(negedge clk);
    reset           = 1'b1;
    bus.mem_op      = OP_RD;
    bus.mem_rw_addr = 16'h0033;
    @(negedge clk);
    bus.mem_op = OP_NOP;
    @(negedge clk);
    check_reset_state("init_rst");
    reset = 1'b0;
    wait_ready("init_restart");

    for (int i = 0; i < int'(SIZE); i++) begin
      drive(OP_RD, 16'(i), 16'h0000);
      push(1'b1, 1'b0, 16'h0000, 16'h0000);
    end
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: %0d outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
